fetch_hazard_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch unit and the IF/ID and ID/EX pipeline registers.
- Drives PC enable and PC-source select.
- Redirects the PC on taken branches resolved in EX.
- Inserts one-cycle bubbles on load-use hazards.
- Holds fetch idle for a fixed startup window after reset.
- Parks the pipeline on a halt instruction until an external resume pulse.
- Sits between the EX/ID stage decode outputs and the fetch unit.

---
 rtl/fetch_hazard_ctrl_pkg.sv | 25 ++
 rtl/fetch_hazard_ctrl_if.sv | 38 +++
 rtl/fetch_hazard_ctrl_load_use_detect.sv | 26 ++
 rtl/fetch_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_fetch_hazard_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared definitions for the fetch/hazard sequencing controller: state encoding,
// the flush NOP and the bundle of pipeline-control strobes.
package hazard_pkg;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_enable;
    logic pc_src;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  // Fetch frozen with both pipeline registers forced to NOP (boot and halt).
  localparam pipe_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_STALL    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_RUN      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// Decode-side inputs and fetch/pipeline-control outputs of the hazard controller.
interface fetch_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic [31:0]           ex_branch_target;
  logic                  ex_halt;
  logic                  resume;
  logic                  PCEnable;
  logic                  PCSrc;
  logic [31:0]           PC_Plus_Immediate;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  halted;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch_taken, ex_branch_target, ex_halt, resume,
    input  PCEnable, PCSrc, PC_Plus_Immediate, if_id_write, if_id_flush,
           id_ex_flush, halted, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch_taken, ex_branch_target, ex_halt, resume,
    output PCEnable, PCSrc, PC_Plus_Immediate, if_id_write, if_id_flush,
           id_ex_flush, halted, stall_count
  );
endinterface

// File: rtl/fetch_hazard_ctrl_load_use_detect.sv
// Load-use hazard comparator: the ID instruction reads a register that the load
// in EX has not yet written. x0 is hardwired to zero, so it never hazards.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  hazard
);

  logic rd_nonzero_s;
  logic rs1_match_s;
  logic rs2_match_s;

  assign rd_nonzero_s = (ex_rd != {REG_ADDR_W{1'b0}});
  assign rs1_match_s  = rs1_used && (rs1 == ex_rd);
  assign rs2_match_s  = rs2_used && (rs2 == ex_rd);
  assign hazard       = ex_mem_read && rd_nonzero_s && (rs1_match_s || rs2_match_s);

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch sequencing controller: boot hold-off, branch redirect, load-use bubbles
// and halt parking. Pipeline strobes are combinational from state and inputs.
module fetch_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int STARTUP_CYCLES = 2,
  parameter int REG_ADDR_W     = 5,
  parameter int CNT_W          = 16
) (
  input logic              clk,
  input logic              rst_,
  fetch_hazard_ctrl_if.slave bus
);

  localparam int BOOT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(STARTUP_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              hazard_s;
  logic              stall_s;
  pipe_ctrl_t        ctrl_s;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
    .rs1         (bus.id_rs1),
    .rs2         (bus.id_rs2),
    .rs1_used    (bus.id_rs1_used),
    .rs2_used    (bus.id_rs2_used),
    .ex_rd       (bus.ex_rd),
    .ex_mem_read (bus.ex_mem_read),
    .hazard      (hazard_s)
  );

  // Next state and pipeline strobes; halt outranks a branch, which outranks a stall.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    ctrl_s     = CTRL_FREEZE;
    stall_s    = 1'b0;
    case (state_q)
      BOOT: begin
        ctrl_s = CTRL_FREEZE;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = RUN;
          boot_cnt_d = {BOOT_W{1'b0}};
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end
      RUN: begin
        if (bus.ex_halt) begin
          ctrl_s  = CTRL_FREEZE;
          state_d = HALT;
        end else if (bus.ex_branch_taken) begin
          ctrl_s = CTRL_REDIRECT;
        end else if (hazard_s) begin
          ctrl_s  = CTRL_STALL;
          stall_s = 1'b1;
        end else begin
          ctrl_s = CTRL_RUN;
        end
      end
      HALT: begin
        ctrl_s = CTRL_FREEZE;
        if (bus.resume) begin
          state_d = RUN;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        ctrl_s     = CTRL_FREEZE;
        state_d    = BOOT;
        boot_cnt_d = {BOOT_W{1'b0}};
      end
    endcase
  end

  // Registered status: halt flag and saturating stall counter.
  always_comb begin
    halted_d = (state_d == HALT);
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and status flops.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= BOOT;
      boot_cnt_q  <= {BOOT_W{1'b0}};
      halted_q    <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.PCEnable          = ctrl_s.pc_enable;
  assign bus.PCSrc             = ctrl_s.pc_src;
  assign bus.if_id_write       = ctrl_s.if_id_write;
  assign bus.if_id_flush       = ctrl_s.if_id_flush;
  assign bus.id_ex_flush       = ctrl_s.id_ex_flush;
  assign bus.PC_Plus_Immediate = bus.ex_branch_target;
  assign bus.halted            = halted_q;
  assign bus.stall_count       = stall_cnt_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed plus randomized bench for fetch_hazard_ctrl against a behavioural model
// that tracks boot cycles remaining, a parked flag and a stall tally.
module tb_fetch_hazard_ctrl;

  localparam int STARTUP = 2;
  localparam int RW      = 5;
  localparam int CW      = 16;
  localparam int CNT_MAX = 65535;

  logic clk = 1'b0;
  logic rst_;

  always #5 clk = ~clk;

  fetch_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  fetch_hazard_ctrl #(
    .STARTUP_CYCLES (STARTUP),
    .REG_ADDR_W     (RW),
    .CNT_W          (CW)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int boot_left;
  bit parked;
  int stalls;

  function automatic bit ref_hazard();
    return bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
           ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
            (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [4:0] e;  // {pce, src, wr, if_flush, ex_flush}
    if (boot_left > 0 || parked || bus.ex_halt) e = 5'b00011;
    else if (bus.ex_branch_taken)               e = 5'b11111;
    else if (ref_hazard())                      e = 5'b00001;
    else                                        e = 5'b10100;
    chk("PCEnable",    32'(bus.PCEnable),    32'(e[4]));
    chk("PCSrc",       32'(bus.PCSrc),       32'(e[3]));
    chk("if_id_write", 32'(bus.if_id_write), 32'(e[2]));
    chk("if_id_flush", 32'(bus.if_id_flush), 32'(e[1]));
    chk("id_ex_flush", 32'(bus.id_ex_flush), 32'(e[0]));
    chk("pc_plus_imm", bus.PC_Plus_Immediate, bus.ex_branch_target);
    chk("halted",      32'(bus.halted),      32'(parked));
    chk("stall_count", 32'(bus.stall_count), 32'(stalls));
  endtask

  // One clock: check mid-cycle, then advance the model on the edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (boot_left > 0) begin
      boot_left--;
    end else if (parked) begin
      if (bus.resume) parked = 1'b0;
    end else if (bus.ex_halt) begin
      parked = 1'b1;
    end else if (!bus.ex_branch_taken && ref_hazard()) begin
      if (stalls < CNT_MAX) stalls++;
    end
    #1;
  endtask

  task automatic idle();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_mem_read = 1'b0;
    bus.ex_branch_taken = 1'b0; bus.ex_branch_target = 32'h0;
    bus.ex_halt = 1'b0; bus.resume = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs2);
    bus.ex_mem_read = 1'b1; bus.ex_rd = rd;
    bus.id_rs2 = rs2; bus.id_rs2_used = 1'b1;
  endtask

  // Asynchronous reset assertion, checked before any clock edge sees it.
  task automatic do_reset();
    rst_ = 1'b0;
    #1;
    boot_left = STARTUP; parked = 1'b0; stalls = 0;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_ = 1'b1;
  endtask

  task automatic randomize_inputs();
    bus.id_rs1 = 5'($urandom_range(0, 3));
    bus.id_rs2 = 5'($urandom_range(0, 3));
    bus.id_rs1_used = 1'($urandom_range(0, 1));
    bus.id_rs2_used = 1'($urandom_range(0, 1));
    bus.ex_rd = 5'($urandom_range(0, 3));
    bus.ex_mem_read = 1'($urandom_range(0, 1));
    bus.ex_branch_taken = ($urandom_range(0, 4) == 0);
    bus.ex_branch_target = $urandom;
    bus.ex_halt = ($urandom_range(0, 15) == 0);
    bus.resume = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    idle();
    do_reset();

    // Boot window, then plain running.
    repeat (STARTUP) tick();
    tick();
    chk("run_after_boot", 32'(bus.PCEnable), 32'd1);

    // Load-use on rs2, then the same against x0.
    set_load_use(5'd5, 5'd5);
    tick();
    chk("stall_once", 32'(bus.stall_count), 32'd1);
    set_load_use(5'd0, 5'd0);
    tick();
    idle();
    tick();

    // Branch overrides a concurrent load-use hazard.
    set_load_use(5'd7, 5'd7);
    bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h0000_0040;
    tick();
    chk("branch_no_stall", 32'(bus.stall_count), 32'd1);
    idle();

    // Halt with concurrent branch; resume in the entry cycle is ignored.
    bus.ex_halt = 1'b1; bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h0000_0080;
    bus.resume = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      bus.ex_halt = 1'(i % 2);
      set_load_use(5'd3, 5'd3);
      tick();
    end
    chk("still_halted", 32'(bus.halted), 32'd1);
    idle();
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    tick();
    chk("resumed", 32'(bus.halted), 32'd0);

    // Back-to-back stalls from consecutive loads.
    for (int i = 0; i < 3; i++) begin
      set_load_use(5'(i + 1), 5'(i + 1));
      tick();
    end
    idle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      tick();
    end

    // Saturation: resume is harmless in RUN and releases any park left behind.
    idle();
    set_load_use(5'd9, 5'd9);
    bus.resume = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    chk("stall_saturated", 32'(bus.stall_count), 32'h0000_FFFF);

    // Reset in the middle of a stall.
    do_reset();
    idle();
    repeat (STARTUP + 1) tick();

    // Reset while parked.
    bus.ex_halt = 1'b1;
    tick();
    idle();
    repeat (3) tick();
    do_reset();
    chk("halt_reset_halted", 32'(bus.halted), 32'd0);
    repeat (STARTUP + 2) tick();
    for (int i = 0; i < 50; i++) begin
      randomize_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
